fifo_stat: RTL and testbench

//  Parametrised synchronous FIFO, successor to the basic fifo: adds fill count,

---
 rtl/fifo_stat.sv | 91 +++++++++
 tb/tb_fifo_stat.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stat.sv
// Synchronous FIFO with fill count, almost-full/empty thresholds, sticky
// overflow/underflow flags, synchronous flush and optional first-word-fall-through.
module fifo_stat #(
   parameter int DATA_SIZE       = 8,
   parameter int ADDR_SPACE_EXP  = 4,
   parameter int ALMOST_FULL_TH  = 12,
   parameter int ALMOST_EMPTY_TH = 2,
   parameter int FWFT            = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clear,
   input  logic                      write_to_fifo,
   input  logic                      read_from_fifo,
   input  logic [DATA_SIZE-1:0]      write_data_in,
   output logic [DATA_SIZE-1:0]      read_data_out,
   output logic                      empty,
   output logic                      full,
   output logic                      almost_empty,
   output logic                      almost_full,
   output logic [ADDR_SPACE_EXP:0]   count,
   output logic                      overflow,
   output logic                      underflow
);

   localparam int DEPTH = 1 << ADDR_SPACE_EXP;
   localparam logic [ADDR_SPACE_EXP:0] DEPTH_W = DEPTH[ADDR_SPACE_EXP:0];
   localparam logic [ADDR_SPACE_EXP:0] AF_W    = ALMOST_FULL_TH[ADDR_SPACE_EXP:0];
   localparam logic [ADDR_SPACE_EXP:0] AE_W    = ALMOST_EMPTY_TH[ADDR_SPACE_EXP:0];

   logic [DATA_SIZE-1:0]      mem [DEPTH];
   logic [ADDR_SPACE_EXP-1:0] wr_ptr, rd_ptr;
   logic [ADDR_SPACE_EXP:0]   next_count;
   logic                      wr_acc, rd_acc;

   // Accept decisions use the registered flags, so a full FIFO with both
   // requests pops only and an empty one pushes only.
   assign wr_acc = write_to_fifo  & ~full;
   assign rd_acc = read_from_fifo & ~empty;

   always_comb begin
      next_count = count;
      case ({wr_acc, rd_acc})
         2'b10:   next_count = count + 1'b1;
         2'b01:   next_count = count - 1'b1;
         default: next_count = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         empty        <= 1'b1;
         full         <= 1'b0;
         almost_empty <= 1'b1;
         almost_full  <= 1'b0;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
         count        <= next_count;
         empty        <= (next_count == '0);
         full         <= (next_count == DEPTH_W);
         almost_empty <= (next_count <= AE_W);
         almost_full  <= (next_count >= AF_W);
         if (write_to_fifo && full)  overflow  <= 1'b1;
         if (read_from_fifo && empty) underflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && !clear && wr_acc) mem[wr_ptr] <= write_data_in;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign read_data_out = empty ? '0 : mem[rd_ptr];
      end else begin : g_reg
         logic [DATA_SIZE-1:0] rd_q;
         always_ff @(posedge clk) begin
            if (reset || clear) rd_q <= '0;
            else if (rd_acc)    rd_q <= mem[rd_ptr];
         end
         assign read_data_out = rd_q;
      end
   endgenerate

endmodule

// File: tb/tb_fifo_stat.sv
// Self-checking bench for fifo_stat: registered-read and FWFT instances share
// stimulus and are compared against a queue-based reference model.
module tb_fifo_stat;

   logic       clk = 1'b0;
   logic       reset, clear, wr, rd;
   logic [7:0] din;

   logic [7:0] dout0, dout1;
   logic [4:0] c0, c1;
   logic       e0, f0, ae0, af0, ov0, un0;
   logic       e1, f1, ae1, af1, ov1, un1;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   logic [7:0] q [$];
   logic       m_ovf, m_unf;
   logic [7:0] m_rd;

   always #5 clk = ~clk;

   fifo_stat #(.DATA_SIZE(8), .ADDR_SPACE_EXP(4), .ALMOST_FULL_TH(12),
               .ALMOST_EMPTY_TH(2), .FWFT(0)) dut (
      .clk(clk), .reset(reset), .clear(clear),
      .write_to_fifo(wr), .read_from_fifo(rd), .write_data_in(din),
      .read_data_out(dout0), .empty(e0), .full(f0), .almost_empty(ae0),
      .almost_full(af0), .count(c0), .overflow(ov0), .underflow(un0));

   fifo_stat #(.DATA_SIZE(8), .ADDR_SPACE_EXP(4), .ALMOST_FULL_TH(12),
               .ALMOST_EMPTY_TH(2), .FWFT(1)) dut_f (
      .clk(clk), .reset(reset), .clear(clear),
      .write_to_fifo(wr), .read_from_fifo(rd), .write_data_in(din),
      .read_data_out(dout1), .empty(e1), .full(f1), .almost_empty(ae1),
      .almost_full(af1), .count(c1), .overflow(ov1), .underflow(un1));

   // Drive one cycle of inputs, advance the model on the edge, sample 1 ns later.
   task automatic cycle(input logic rst, input logic clr, input logic w,
                        input logic r, input logic [7:0] d);
      bit was_full, was_empty;
      reset = rst; clear = clr; wr = w; rd = r; din = d;
      @(posedge clk);
      if (rst || clr) begin
         q.delete();
         m_ovf = 1'b0; m_unf = 1'b0; m_rd = 8'h00;
      end else begin
         was_full  = (q.size() == 16);
         was_empty = (q.size() == 0);
         if (w && was_full)  m_ovf = 1'b1;
         if (r && was_empty) m_unf = 1'b1;
         if (r && !was_empty) m_rd = q.pop_front();
         if (w && !was_full) q.push_back(d);
      end
      #1;
   endtask

   task automatic test_reset();
      cycle(1, 0, 0, 0, 8'h00);
      cycle(1, 0, 0, 0, 8'h00);
      cycle(0, 0, 0, 0, 8'h00);
      n_checks++;
      if ({e0, f0, ae0, af0, ov0, un0, c0, dout0} !== {6'b101000, 5'd0, 8'h00}) begin
         n_errors++;
         $display("FAIL reset_state0 got e=%b f=%b ae=%b af=%b ov=%b un=%b cnt=%0d d=%h", e0, f0, ae0, af0, ov0, un0, c0, dout0);
      end
      n_checks++;
      if ({e1, f1, ae1, af1, ov1, un1, c1, dout1} !== {6'b101000, 5'd0, 8'h00}) begin
         n_errors++;
         $display("FAIL reset_state1 got e=%b f=%b ae=%b af=%b ov=%b un=%b cnt=%0d d=%h", e1, f1, ae1, af1, ov1, un1, c1, dout1);
      end
   endtask

   task automatic test_write_read();
      logic [7:0] exp;
      for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, 8'h11 + 8'(i));
      n_checks++;
      if (c0 !== 5'd5) begin n_errors++; $display("FAIL wr5_count got %0d want 5", c0); end
      for (int i = 0; i < 5; i++) begin
         cycle(0, 0, 0, 1, 8'h00);
         exp = 8'h11 + 8'(i);
         n_checks++;
         if (dout0 !== exp) begin
            n_errors++; $display("FAIL rd_data[%0d] got %h want %h", i, dout0, exp);
         end
      end
      n_checks++;
      if (e0 !== 1'b1) begin n_errors++; $display("FAIL rd5_empty got %b want 1", e0); end
   endtask

   task automatic test_fill();
      for (int k = 1; k <= 16; k++) begin
         cycle(0, 0, 1, 0, 8'h30 + 8'(k - 1));
         n_checks++;
         if ({c0, af0, f0} !== {5'(k), k >= 12, k == 16}) begin
            n_errors++;
            $display("FAIL fill[%0d] got cnt=%0d af=%b full=%b want cnt=%0d af=%b full=%b", k, c0, af0, f0, k, k >= 12, k == 16);
         end
      end
      cycle(0, 0, 1, 0, 8'hFF);
      n_checks++;
      if ({c0, f0, ov0, un0} !== {5'd16, 1'b1, 1'b1, 1'b0}) begin
         n_errors++; $display("FAIL overflow got cnt=%0d full=%b ov=%b un=%b want 16 1 1 0", c0, f0, ov0, un0);
      end
   endtask

   task automatic test_simultaneous();
      cycle(0, 0, 1, 1, 8'hEE);
      n_checks++;
      if ({c0, f0, ov0, dout0} !== {5'd15, 1'b0, 1'b1, 8'h30}) begin
         n_errors++; $display("FAIL full_wr_rd got cnt=%0d full=%b ov=%b d=%h want 15 0 1 30", c0, f0, ov0, dout0);
      end
      cycle(0, 1, 0, 0, 8'h00);
      cycle(0, 0, 1, 1, 8'h77);
      n_checks++;
      if ({c0, e0, un0, ov0, dout0} !== {5'd1, 1'b0, 1'b1, 1'b0, 8'h00}) begin
         n_errors++; $display("FAIL empty_wr_rd got cnt=%0d e=%b un=%b ov=%b d=%h want 1 0 1 0 00", c0, e0, un0, ov0, dout0);
      end
      cycle(0, 0, 0, 1, 8'h00);
      n_checks++;
      if (dout0 !== 8'h77) begin n_errors++; $display("FAIL empty_wr_rd_pop got %h want 77", dout0); end
   endtask

   task automatic test_wrap_clear();
      int wrote = 0, readn = 0;
      logic w, r;
      logic [10:0] exp_s, act_s;
      cycle(0, 1, 0, 0, 8'h00);
      for (int i = 0; i < 200 && (wrote < 20 || readn < 20); i++) begin
         w = (wrote < 20) && ($urandom_range(0, 99) < 60);
         r = (readn < 20) && (q.size() > 0) && ($urandom_range(0, 99) < 50);
         if (w && q.size() == 16) w = 1'b0;
         cycle(0, 0, w, r, 8'($urandom));
         if (w) wrote++;
         if (r) readn++;
         exp_s = {5'(q.size()), q.size() == 0, q.size() == 16, q.size() <= 2, q.size() >= 12, m_ovf, m_unf};
         act_s = {c0, e0, f0, ae0, af0, ov0, un0};
         n_checks++;
         if (act_s !== exp_s) begin n_errors++; $display("FAIL wrap_status[%0d] got %b want %b", i, act_s, exp_s); end
         n_checks++;
         if (r && dout0 !== m_rd) begin n_errors++; $display("FAIL wrap_data[%0d] got %h want %h", i, dout0, m_rd); end
      end
      n_checks++;
      if (readn != 20) begin n_errors++; $display("FAIL wrap_budget got %0d reads want 20", readn); end
      for (int i = 0; i < 5; i++) cycle(0, 0, 1, i == 4, 8'h50 + 8'(i));
      cycle(0, 0, 1, 1, 8'hAA);
      cycle(0, 1, 0, 0, 8'h00);
      n_checks++;
      if ({c0, e0, f0, ae0, af0, ov0, un0, dout0} !== {5'd0, 6'b101000, 8'h00}) begin
         n_errors++; $display("FAIL clear got cnt=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b d=%h", c0, e0, f0, ae0, af0, ov0, un0, dout0);
      end
   endtask

   task automatic test_fwft();
      cycle(0, 1, 0, 0, 8'h00);
      cycle(0, 0, 1, 0, 8'hA5);
      n_checks++;
      if ({e1, dout1} !== {1'b0, 8'hA5}) begin
         n_errors++; $display("FAIL fwft_visible got e=%b d=%h want 0 a5", e1, dout1);
      end
      cycle(0, 0, 0, 1, 8'h00);
      n_checks++;
      if ({e1, dout1} !== {1'b1, 8'h00}) begin
         n_errors++; $display("FAIL fwft_pop got e=%b d=%h want 1 00", e1, dout1);
      end
   endtask

   task automatic test_random();
      logic rs, cl, w, r;
      logic [10:0] exp_s, act0, act1;
      logic [7:0] exp_f;
      for (int i = 0; i < 600; i++) begin
         rs = ($urandom_range(0, 199) == 0);
         cl = ($urandom_range(0, 99) == 0);
         w  = ($urandom_range(0, 99) < ((i / 75) % 2 == 0 ? 75 : 30));
         r  = ($urandom_range(0, 99) < ((i / 75) % 2 == 0 ? 30 : 75));
         cycle(rs, cl, w, r, 8'($urandom));
         exp_s = {5'(q.size()), q.size() == 0, q.size() == 16, q.size() <= 2, q.size() >= 12, m_ovf, m_unf};
         exp_f = (q.size() == 0) ? 8'h00 : q[0];
         act0  = {c0, e0, f0, ae0, af0, ov0, un0};
         act1  = {c1, e1, f1, ae1, af1, ov1, un1};
         n_checks++;
         if (act0 !== exp_s) begin n_errors++; $display("FAIL rnd_status0[%0d] got %b want %b", i, act0, exp_s); end
         n_checks++;
         if (act1 !== exp_s) begin n_errors++; $display("FAIL rnd_status1[%0d] got %b want %b", i, act1, exp_s); end
         n_checks++;
         if (dout0 !== m_rd) begin n_errors++; $display("FAIL rnd_data0[%0d] got %h want %h", i, dout0, m_rd); end
         n_checks++;
         if (dout1 !== exp_f) begin n_errors++; $display("FAIL rnd_data1[%0d] got %h want %h", i, dout1, exp_f); end
      end
   endtask

   initial begin
      reset = 1'b1; clear = 1'b0; wr = 1'b0; rd = 1'b0; din = 8'h00;
      m_ovf = 1'b0; m_unf = 1'b0; m_rd = 8'h00;
      test_reset();
      test_write_read();
      test_fill();
      test_simultaneous();
      test_wrap_clear();
      test_fwft();
      test_random();
      cycle(0, 0, 0, 0, 8'h00);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
